// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues word addresses to a 1-cycle synchronous instruction memory
// and hands (pc, instruction) pairs to decode over valid/ready. Define FETCH_PERF_EN for perf counters.
module fetch_unit #(
  parameter int unsigned             PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]     RESET_PC   = '0,
  parameter int unsigned             ADDR_WIDTH = 10
) (
  input  logic                clock,
  input  logic                reset,
  output logic [31:0]         instructionAddress,
  input  logic [31:0]         instruction,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                fetch_valid,
  input  logic                fetch_ready,
  output logic [PC_WIDTH-1:0] fetch_pc,
  output logic [31:0]         fetch_instruction
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_squashed
`endif
);

  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] a);
    return a & ~PC_WIDTH'(3);
  endfunction

  function automatic logic [PC_WIDTH-1:0] incr_pc(input logic [PC_WIDTH-1:0] a);
    return a + PC_WIDTH'(4);
  endfunction

  // Byte address -> word index, wrapping inside the memory's ADDR_WIDTH-bit index space.
  function automatic logic [31:0] word_index(input logic [PC_WIDTH-1:0] a);
    logic [PC_WIDTH-1:0] w;
    w = (a >> 2) & ((PC_WIDTH'(1) << ADDR_WIDTH) - PC_WIDTH'(1));
    return 32'(w);
  endfunction

  logic [PC_WIDTH-1:0] pc_p0;
  logic [PC_WIDTH-1:0] req_pc_p1;
  logic                vld_p1;
  logic                stall;
  logic [PC_WIDTH-1:0] issue_pc;

  assign stall = vld_p1 & ~fetch_ready & ~redirect_valid;

  // Stage 0: choose the PC sent to memory; a stall re-reads the held word so the data stays put.
  always_comb begin
    issue_pc = pc_p0;
    if (redirect_valid)
      issue_pc = align_pc(redirect_pc);
    else if (stall)
      issue_pc = req_pc_p1;
  end

  assign instructionAddress = word_index(issue_pc);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_p0     <= align_pc(RESET_PC);
      req_pc_p1 <= align_pc(RESET_PC);
      vld_p1    <= 1'b0;
    end else if (!stall) begin
      req_pc_p1 <= issue_pc;
      pc_p0     <= incr_pc(issue_pc);
      vld_p1    <= 1'b1;
    end
  end

  // Stage 1: memory data arrives for req_pc_p1; a redirect squashes it in the same cycle.
  assign fetch_valid       = vld_p1 & ~redirect_valid;
  assign fetch_pc          = req_pc_p1;
  assign fetch_instruction = instruction;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      if (fetch_valid && fetch_ready)
        perf_fetched <= perf_fetched + 32'd1;
      if (vld_p1 && redirect_valid)
        perf_squashed <= perf_squashed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: 1-cycle memory model, expected transfers queued as stimulus is driven
// and popped on every decode handshake, plus direct checks of address, stall and reset behaviour.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instructionAddress;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instruction;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_pc[$];

  always #5 clock = ~clock;

  fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0), .ADDR_WIDTH(10)) dut (
    .clock              (clock),
    .reset              (reset),
    .instructionAddress (instructionAddress),
    .instruction        (instruction),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .fetch_valid        (fetch_valid),
    .fetch_ready        (fetch_ready),
    .fetch_pc           (fetch_pc),
    .fetch_instruction  (fetch_instruction)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched       (perf_fetched),
    .perf_squashed      (perf_squashed)
`endif
  );

  function automatic logic [31:0] memword(input logic [9:0] idx);
    return {16'hC0DE, 6'b0, idx};
  endfunction

  // Word index a byte PC lands on in a 1024-word memory.
  function automatic logic [9:0] pc_idx(input logic [31:0] pc);
    return pc[11:2];
  endfunction

  always @(posedge clock) instruction <= memword(instructionAddress[9:0]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    sb_pc.push_back(pc);
  endtask

  // Every decode handshake must match the next queued (pc, memory word) pair.
  always @(negedge clock) begin
    if (!reset && fetch_valid && fetch_ready) begin
      if (sb_pc.size() == 0) begin
        check("sb_unexpected_xfer", fetch_pc, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] exp_pc;
        exp_pc = sb_pc.pop_front();
        check("xfer_pc", fetch_pc, exp_pc);
        check("xfer_instr", fetch_instruction, memword(pc_idx(exp_pc)));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; fetch_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) step();
    #2;
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_pc", fetch_pc, 32'h0);
    check("rst_addr", instructionAddress, 32'd0);

    for (int i = 0; i < 4; i++) push(32'(i * 4));
    reset = 1'b0;
    #1;
    check("first_valid", 32'(fetch_valid), 32'd0);
    check("first_addr", instructionAddress, 32'd0);
    step(); #2;
    check("b_valid", 32'(fetch_valid), 32'd1);
    check("b_addr", instructionAddress, 32'd1);
    step(); #2;
    check("c_addr", instructionAddress, 32'd2);

    // Decode back-pressure for 3 cycles while pc 8 is presented.
    for (int i = 0; i < 3; i++) begin
      step();
      fetch_ready = 1'b0;
      #2;
      check("stall_valid", 32'(fetch_valid), 32'd1);
      check("stall_pc", fetch_pc, 32'h8);
      check("stall_instr", fetch_instruction, memword(10'd2));
      check("stall_addr", instructionAddress, 32'd2);
    end
    step();
    fetch_ready = 1'b1;
    #2;
    check("resume_addr", instructionAddress, 32'd3);
    step();
    step();

    // Redirect to 0x40 while 0x10 is presented.
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    push(32'h40);
    #2;
    check("redir_pc_held", fetch_pc, 32'h10);
    check("redir_valid", 32'(fetch_valid), 32'd0);
    check("redir_addr", instructionAddress, 32'd16);
    step();
    redirect_valid = 1'b0;
    #2;
    check("post_redir_addr", instructionAddress, 32'd17);
    step();

    // Stall on 0x44, then redirect to an unaligned 0x23 drops it.
    fetch_ready = 1'b0;
    #2;
    check("stall44_addr", instructionAddress, 32'd17);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h23;
    push(32'h20); push(32'h24);
    #2;
    check("stall_redir_valid", 32'(fetch_valid), 32'd0);
    check("stall_redir_addr", instructionAddress, 32'd8);
    step();
    redirect_valid = 1'b0; fetch_ready = 1'b1;
    step();
    step();

    // Memory index wrap at 0x1000.
    redirect_valid = 1'b1; redirect_pc = 32'hFF8;
    push(32'hFF8); push(32'hFFC); push(32'h1000);
    step();
    redirect_valid = 1'b0;
    step();
    #2;
    check("idx_wrap_addr", instructionAddress, 32'd0);
    step();
    step();

    // Full 32-bit PC wrap.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    push(32'hFFFF_FFF8); push(32'hFFFF_FFFC); push(32'h0);
    step();
    redirect_valid = 1'b0;
    repeat (3) step();

    // Asynchronous reset in the middle of a presented instruction.
    fetch_ready = 1'b0;
    #1;
    check("pre_async_valid", 32'(fetch_valid), 32'd1);
    check("pre_async_pc", fetch_pc, 32'h4);
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, 32'd13);
    check("perf_squashed", perf_squashed, 32'd4);
`endif
    #1;
    reset = 1'b1;
    #1;
    check("async_valid", 32'(fetch_valid), 32'd0);
    check("async_pc", fetch_pc, 32'h0);
    check("async_addr", instructionAddress, 32'd0);
    repeat (2) step();
    push(32'h0); push(32'h4);
    reset = 1'b0; fetch_ready = 1'b1;
    #2;
    check("restart_valid", 32'(fetch_valid), 32'd0);
    check("restart_addr", instructionAddress, 32'd0);
    step();
    step();
    step();
    fetch_ready = 1'b0;
    step();
    check("sb_drain", 32'(sb_pc.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
